// File: rtl/mysoc_sysid_pkg.sv
// Shared definitions for the system-ID boot checker: word addresses, data width
// and the checker state encoding.
package mysoc_sysid_pkg;

  localparam int   SYSID_DATA_W  = 32;
  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RD_ID  = 3'd1;
  localparam logic [2:0] ST_LAT_ID = 3'd2;
  localparam logic [2:0] ST_RD_TS  = 3'd3;
  localparam logic [2:0] ST_LAT_TS = 3'd4;
  localparam logic [2:0] ST_FINISH = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_RD_ID  = ST_RD_ID,
    S_LAT_ID = ST_LAT_ID,
    S_RD_TS  = ST_RD_TS,
    S_LAT_TS = ST_LAT_TS,
    S_FINISH = ST_FINISH
  } sysid_state_e;

  function automatic logic word_mismatch(input logic [SYSID_DATA_W-1:0] got,
                                         input logic [SYSID_DATA_W-1:0] want);
    return got != want;
  endfunction

endpackage

// File: rtl/mysoc_avm_single_read.sv
// One Avalon-MM read helper: drives the request while the owner is in a read
// state, tracks read latency and the per-transaction timeout budget.
module mysoc_avm_single_read
  import mysoc_sysid_pkg::*;
#(
  parameter int READ_LATENCY   = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clear_i,
  input  logic                    rd_i,
  input  logic                    lat_i,
  input  logic                    addr_i,
  input  logic                    av_waitrequest_i,
  input  logic [SYSID_DATA_W-1:0] av_readdata_i,
  output logic                    av_read_o,
  output logic                    av_address_o,
  output logic                    accept_o,
  output logic                    data_valid_o,
  output logic                    timed_out_o,
  output logic [SYSID_DATA_W-1:0] data_o
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]  LAT_LAST = 2'(READ_LATENCY - 1);

  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic [1:0]  lat_cnt_q, lat_cnt_d;
  logic        active;

  assign active       = rd_i | lat_i;
  assign av_read_o    = rd_i;
  assign av_address_o = addr_i;
  assign accept_o     = rd_i & ~av_waitrequest_i;
  assign data_o       = av_readdata_i;
  assign data_valid_o = (READ_LATENCY == 0) ? accept_o
                                            : (lat_i && (lat_cnt_q == LAT_LAST));
  // Data arriving on the last budgeted cycle still wins over the timeout.
  assign timed_out_o  = active && (tmo_cnt_q == TMO_LAST) && !data_valid_o;

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    lat_cnt_d = lat_cnt_q;
    if (clear_i)     tmo_cnt_d = '0;
    else if (active) tmo_cnt_d = tmo_cnt_q + 16'd1;
    if (accept_o)    lat_cnt_d = '0;
    else if (lat_i)  lat_cnt_d = lat_cnt_q + 2'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tmo_cnt_q <= '0;
      lat_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      lat_cnt_q <= lat_cnt_d;
    end
  end

endmodule

// File: rtl/mysoc_sysid_checker.sv
// Boot-time system-ID checker: reads the ID and timestamp words once, compares
// them with build constants and reports pass/fail before the SoC is released.
module mysoc_sysid_checker
  import mysoc_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1647291630,
  parameter int          READ_LATENCY   = 0,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        av_address,
  output logic        av_read,
  input  logic        av_waitrequest,
  input  logic [31:0] av_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        err_id,
  output logic        err_ts,
  output logic        err_timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  sysid_state_e state_q, state_d;
  logic auto_q, auto_d, busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic err_id_q, err_id_d, err_ts_q, err_ts_d, err_to_q, err_to_d;
  logic id_rd_q, id_rd_d, ts_rd_q, ts_rd_d;
  logic [SYSID_DATA_W-1:0] id_q, id_d, ts_q, ts_d, rd_data;
  logic clear, rd, lat, addr, accept, data_valid, timed_out;

  assign rd   = (state_q == S_RD_ID)  || (state_q == S_RD_TS);
  assign lat  = (state_q == S_LAT_ID) || (state_q == S_LAT_TS);
  assign addr = ((state_q == S_RD_TS) || (state_q == S_LAT_TS)) ? SYSID_ADDR_TS : SYSID_ADDR_ID;

  mysoc_avm_single_read #(
    .READ_LATENCY  (READ_LATENCY),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rd (
    .clk_i           (clock),
    .rst_i           (reset),
    .clear_i         (clear),
    .rd_i            (rd),
    .lat_i           (lat),
    .addr_i          (addr),
    .av_waitrequest_i(av_waitrequest),
    .av_readdata_i   (av_readdata),
    .av_read_o       (av_read),
    .av_address_o    (av_address),
    .accept_o        (accept),
    .data_valid_o    (data_valid),
    .timed_out_o     (timed_out),
    .data_o          (rd_data)
  );

  always_comb begin
    state_d  = state_q;  auto_d   = auto_q;   busy_d   = busy_q;   done_d  = done_q;
    pass_d   = pass_q;   err_id_d = err_id_q; err_ts_d = err_ts_q; err_to_d = err_to_q;
    id_d     = id_q;     ts_d     = ts_q;     id_rd_d  = id_rd_q;  ts_rd_d  = ts_rd_q;
    clear    = 1'b0;
    case (state_q)
      S_IDLE: if (start || auto_q) begin
        state_d  = S_RD_ID; clear  = 1'b1; auto_d   = 1'b0; busy_d   = 1'b1;
        done_d   = 1'b0;    pass_d = 1'b0; err_id_d = 1'b0; err_ts_d = 1'b0;
        err_to_d = 1'b0;    id_d   = '0;   ts_d     = '0;   id_rd_d  = 1'b0;
        ts_rd_d  = 1'b0;
      end
      S_RD_ID, S_LAT_ID: begin
        if (data_valid) begin
          id_d = rd_data; id_rd_d = 1'b1; state_d = S_RD_TS; clear = 1'b1;
        end else if (timed_out) begin
          err_to_d = 1'b1; state_d = S_FINISH;
        end else if (accept) begin
          state_d = S_LAT_ID;
        end
      end
      S_RD_TS, S_LAT_TS: begin
        if (data_valid) begin
          ts_d = rd_data; ts_rd_d = 1'b1; state_d = S_FINISH;
        end else if (timed_out) begin
          err_to_d = 1'b1; state_d = S_FINISH;
        end else if (accept) begin
          state_d = S_LAT_TS;
        end
      end
      // A word that was never read cannot mismatch; only the timeout flags it.
      S_FINISH: begin
        err_id_d = id_rd_q && word_mismatch(id_q, EXPECTED_ID);
        err_ts_d = ts_rd_q && word_mismatch(ts_q, EXPECTED_TS);
        pass_d   = !(err_id_d || err_ts_d || err_to_q);
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE; auto_q   <= AUTO_START; busy_q  <= 1'b0; done_q  <= 1'b0;
      pass_q   <= 1'b0;   err_id_q <= 1'b0;       err_ts_q <= 1'b0; err_to_q <= 1'b0;
      id_q     <= '0;     ts_q     <= '0;         id_rd_q <= 1'b0;  ts_rd_q <= 1'b0;
    end else begin
      state_q  <= state_d;  auto_q   <= auto_d;   busy_q   <= busy_d;   done_q   <= done_d;
      pass_q   <= pass_d;   err_id_q <= err_id_d; err_ts_q <= err_ts_d; err_to_q <= err_to_d;
      id_q     <= id_d;     ts_q     <= ts_d;     id_rd_q  <= id_rd_d;  ts_rd_q  <= ts_rd_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign err_id      = err_id_q;
  assign err_ts      = err_ts_q;
  assign err_timeout = err_to_q;
  assign id_value    = id_q;
  assign ts_value    = ts_q;

endmodule

// File: tb/tb_mysoc_sysid_checker.sv
// Bench for mysoc_sysid_checker: two instances (latency 0 / timeout 8 and
// latency 2 / timeout 255) against stall-programmable slave models.
module tb_mysoc_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1647291630;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start   [2] = '{1'b0, 1'b0};
  logic        av_read [2];
  logic        av_addr [2];
  logic        wr      [2];
  logic        busy    [2];
  logic        done    [2];
  logic        pass    [2];
  logic        e_id    [2];
  logic        e_ts    [2];
  logic        e_to    [2];
  logic [31:0] rdata   [2];
  logic [31:0] idv     [2];
  logic [31:0] tsv     [2];

  logic [31:0] mem   [2][2];
  int          stall [2][2];
  int          scnt  [2] = '{0, 0};
  logic [31:0] junk  [2] = '{32'hdead_beef, 32'h1234_5678};
  logic        p1_v = 1'b0, p1_a = 1'b0, p2_v = 1'b0, p2_a = 1'b0;

  int          rd_cyc  [2] = '{0, 0};
  int          acc_n   [2] = '{0, 0};
  int          jumps   [2] = '{0, 0};
  logic [7:0]  acc_log [2] = '{8'h0, 8'h0};
  logic        prev_stall [2] = '{1'b0, 1'b0};
  logic        prev_addr  [2] = '{1'b0, 1'b0};

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Slave: stalls the first stall[addr] cycles of each request; data is only
  // valid in the cycle the master is entitled to sample it, junk otherwise.
  assign wr[0]    = av_read[0] && (scnt[0] < stall[0][av_addr[0]]);
  assign wr[1]    = av_read[1] && (scnt[1] < stall[1][av_addr[1]]);
  assign rdata[0] = (av_read[0] && !wr[0]) ? mem[0][av_addr[0]] : junk[0];
  assign rdata[1] = p2_v ? mem[1][p2_a] : junk[1];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      scnt[d] <= (av_read[d] && wr[d]) ? scnt[d] + 1 : 0;
      junk[d] <= $urandom;
    end
    p1_v <= av_read[1] && !wr[1];
    p1_a <= av_addr[1];
    p2_v <= p1_v;
    p2_a <= p1_a;
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (av_read[d]) rd_cyc[d] = rd_cyc[d] + 1;
      if (av_read[d] && prev_stall[d] && (av_addr[d] != prev_addr[d])) jumps[d] = jumps[d] + 1;
      if (av_read[d] && !wr[d]) begin
        acc_n[d]   = acc_n[d] + 1;
        acc_log[d] = {acc_log[d][6:0], av_addr[d]};
      end
      prev_stall[d] = av_read[d] && wr[d];
      prev_addr[d]  = av_addr[d];
    end
  end

  mysoc_sysid_checker #(.READ_LATENCY(0), .TIMEOUT_CYCLES(8)) dut0 (
    .clock(clk), .reset(rst), .start(start[0]),
    .av_address(av_addr[0]), .av_read(av_read[0]), .av_waitrequest(wr[0]),
    .av_readdata(rdata[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .err_id(e_id[0]), .err_ts(e_ts[0]), .err_timeout(e_to[0]),
    .id_value(idv[0]), .ts_value(tsv[0])
  );

  mysoc_sysid_checker #(.READ_LATENCY(2), .TIMEOUT_CYCLES(255)) dut1 (
    .clock(clk), .reset(rst), .start(start[1]),
    .av_address(av_addr[1]), .av_read(av_read[1]), .av_waitrequest(wr[1]),
    .av_readdata(rdata[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .err_id(e_id[1]), .err_ts(e_ts[1]), .err_timeout(e_to[1]),
    .id_value(idv[1]), .ts_value(tsv[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model: each word costs stall+1+latency cycles unless that exceeds the
  // timeout budget, in which case the check stops after exactly the budget.
  task automatic run_check(input int d, input bit pulse, input logic [31:0] idw,
                           input logic [31:0] tsw, input int s_id, input int s_ts,
                           input int poke, input string tag);
    int lat, tmo, need, dur, rdx, n_acc, cyc, w, b_rd, b_acc, b_j;
    bit to_id, to_ts, rd_id, rd_ts, x_eid, x_ets, x_eto;
    logic [7:0] x_log, msk;
    w = 0;
    while (busy[d] && w < 1000) begin @(posedge clk); #1; w++; end
    chk({tag, "_idle_before"}, busy[d], 0);
    lat = (d == 1) ? 2 : 0;
    tmo = (d == 1) ? 255 : 8;
    mem[d][0] = idw; mem[d][1] = tsw; stall[d][0] = s_id; stall[d][1] = s_ts;

    dur = 2; rdx = 0; n_acc = 0; to_ts = 0; rd_ts = 0;
    need  = s_id + 1 + lat;
    to_id = need > tmo;
    dur  += to_id ? tmo : need;
    rdx  += (s_id + 1 > tmo) ? tmo : s_id + 1;
    n_acc += (s_id + 1 <= tmo) ? 1 : 0;
    rd_id = !to_id;
    if (rd_id) begin
      need  = s_ts + 1 + lat;
      to_ts = need > tmo;
      dur  += to_ts ? tmo : need;
      rdx  += (s_ts + 1 > tmo) ? tmo : s_ts + 1;
      n_acc += (s_ts + 1 <= tmo) ? 1 : 0;
      rd_ts = !to_ts;
    end
    x_eid = rd_id && (idw != EXP_ID);
    x_ets = rd_ts && (tsw != EXP_TS);
    x_eto = to_id || to_ts;
    x_log = (n_acc == 2) ? 8'h01 : 8'h00;
    msk   = (n_acc == 2) ? 8'h03 : 8'h01;

    b_rd = rd_cyc[d]; b_acc = acc_n[d]; b_j = jumps[d];
    if (pulse) start[d] = 1'b1;
    @(posedge clk); #1;
    start[d] = 1'b0;
    cyc = 1;
    chk({tag, "_busy_after_start"}, busy[d], 1);
    chk({tag, "_cleared_at_start"}, {done[d], pass[d], e_id[d], e_ts[d], e_to[d]}, 0);
    while (!done[d] && cyc < 3000) begin
      start[d] = (cyc == poke);
      @(posedge clk); #1;
      cyc++;
    end
    start[d] = 1'b0;
    chk({tag, "_duration"}, cyc, dur);
    chk({tag, "_done"}, done[d], 1);
    chk({tag, "_busy_end"}, busy[d], 0);
    chk({tag, "_pass"}, pass[d], !(x_eid || x_ets || x_eto));
    chk({tag, "_err_id"}, e_id[d], x_eid);
    chk({tag, "_err_ts"}, e_ts[d], x_ets);
    chk({tag, "_err_timeout"}, e_to[d], x_eto);
    chk({tag, "_id_value"}, idv[d], rd_id ? idw : 32'd0);
    chk({tag, "_ts_value"}, tsv[d], rd_ts ? tsw : 32'd0);
    chk({tag, "_read_cycles"}, rd_cyc[d] - b_rd, rdx);
    chk({tag, "_accepts"}, acc_n[d] - b_acc, n_acc);
    if (n_acc > 0) chk({tag, "_addr_order"}, acc_log[d] & msk, x_log);
    chk({tag, "_addr_stable"}, jumps[d] - b_j, 0);
    @(posedge clk); #1;
    chk({tag, "_stays_idle"}, busy[d], 0);
    chk({tag, "_done_held"}, done[d], 1);
  endtask

  initial begin
    int cyc, d, s_id, s_ts;
    logic [31:0] idw, tsw;
    for (int i = 0; i < 2; i++) begin
      mem[i][0] = EXP_ID; mem[i][1] = EXP_TS; stall[i][0] = 0; stall[i][1] = 0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("reset_ctrl", {busy[i], done[i], pass[i], e_id[i], e_ts[i], e_to[i], av_read[i]}, 0);
      chk("reset_id_value", idv[i], 0);
      chk("reset_ts_value", tsv[i], 0);
    end
    rst = 1'b0;

    run_check(0, 1'b0, EXP_ID, EXP_TS, 0, 0, -1, "T1_auto");
    run_check(0, 1'b1, 32'h1, EXP_TS, 0, 0, -1, "T2_bad_id");
    run_check(1, 1'b1, EXP_ID, EXP_TS, 3, 3, -1, "T3_stall_lat");
    run_check(0, 1'b1, EXP_ID, EXP_TS, 0, 1000, -1, "T4_ts_stuck");
    run_check(0, 1'b1, EXP_ID, EXP_TS, 7, 0, -1, "edge_tmo_minus1");
    run_check(0, 1'b1, EXP_ID, EXP_TS, 8, 0, -1, "edge_tmo_id");
    run_check(0, 1'b1, 32'h5, EXP_TS, 4, 0, 3, "T5_start_busy");
    run_check(0, 1'b1, EXP_ID, EXP_TS, 0, 0, 3, "T5_start_finish");

    mem[0][0] = EXP_ID; mem[0][1] = EXP_TS; stall[0][0] = 0; stall[0][1] = 20;
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    cyc = 0;
    while (!(av_read[0] && av_addr[0]) && cyc < 50) begin @(posedge clk); #1; cyc++; end
    chk("T6_in_rd_ts", {av_read[0], av_addr[0]}, 2'b11);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("T6_async_av_read", av_read[0], 0);
    chk("T6_async_busy", busy[0], 0);
    chk("T6_async_done", {done[0], done[1]}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_check(0, 1'b0, EXP_ID, EXP_TS, 0, 0, -1, "T6_after_reset");

    for (int i = 0; i < 16; i++) begin
      d    = i % 2;
      idw  = ($urandom_range(0, 1) == 1) ? EXP_ID : $urandom;
      tsw  = ($urandom_range(0, 1) == 1) ? EXP_TS : $urandom;
      s_id = $urandom_range(0, (d == 1) ? 6 : 10);
      s_ts = $urandom_range(0, (d == 1) ? 6 : 10);
      if ($urandom_range(0, 5) == 0) s_ts = 300;
      run_check(d, 1'b1, idw, tsw, s_id, s_ts, -1, "RND");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
